execute_writeback: RTL

Clocked execute stage directly downstream of `decode`. It accepts one operand bundle at a time over decode's level-ready/toggle-trigger handshake and synchronises that handshake into `clk`. It evaluates one of eight data-processing operations and updates NZCV flags. Register results go to the regbank write port (`triggerInw`/`dataIn`/`addrw`) over the same toggle-style handshake.

---
 rtl/execute_writeback.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/execute_writeback.sv
// execute_writeback: clocked execute stage behind decode. Captures one operand
// bundle per toggle handshake, evaluates one of eight ALU ops, and forwards
// register results to the regbank write port over a second toggle handshake.
// Optional feature macro: EXEC_FLAGS_EN builds the NZCV flag logic.
module execute_writeback #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  readyIn,
    input  logic [DATA_WIDTH-1:0] data1In,
    input  logic [DATA_WIDTH-1:0] data2In,
    input  logic [DATA_WIDTH-1:0] data3In,
    input  logic [DATA_WIDTH-1:0] data4In,
    input  logic [3:0]            typeIn,
    output logic                  triggerOut,
    input  logic                  readyInW,
    output logic                  triggerOutW,
    output logic [DATA_WIDTH-1:0] addrW,
    output logic [DATA_WIDTH-1:0] dataW,
    output logic [3:0]            flagsOut,
    output logic                  busy
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_ORR = 4'd3;
    localparam logic [OP_W-1:0] OP_EOR = 4'd4;
    localparam logic [OP_W-1:0] OP_MOV = 4'd5;
    localparam logic [OP_W-1:0] OP_CMP = 4'd6;
    localparam logic [OP_W-1:0] OP_MVN = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_WB_LO = 3'd2,
        S_WB_HI = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_rdy_sync;
    logic [SYNC_STAGES-1:0]  r_rdyw_sync;
    logic                    w_rdy_s;
    logic                    w_rdyw_s;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [IDX_W-1:0]        r_dst;
    logic [OP_W-1:0]         r_op;
    logic                    r_wsent;
    logic                    r_trig;
    logic                    r_trigw;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_addrw;
    logic [DATA_WIDTH-1:0]   r_dataw;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_writes;

    assign w_rdy_s     = r_rdy_sync[SYNC_STAGES-1];
    assign w_rdyw_s    = r_rdyw_sync[SYNC_STAGES-1];
    assign triggerOut  = r_trig;
    assign triggerOutW = r_trigw;
    assign addrW       = r_addrw;
    assign dataW       = r_dataw;
    assign busy        = r_busy;

    // Bring both level-ready handshakes into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_sync  <= '0;
            r_rdyw_sync <= '0;
        end else begin
            r_rdy_sync  <= {r_rdy_sync[SYNC_STAGES-2:0], readyIn};
            r_rdyw_sync <= {r_rdyw_sync[SYNC_STAGES-2:0], readyInW};
        end
    end

    // ALU on the captured bundle; opcodes 8-15 are NOPs
    always_comb begin
        w_sum    = {1'b0, r_a} + {1'b0, r_b};
        w_diff   = {1'b0, r_a} - {1'b0, r_b};
        w_result = '0;
        case (r_op)
            OP_ADD:         w_result = w_sum[MSB:0];
            OP_SUB, OP_CMP: w_result = w_diff[MSB:0];
            OP_AND:         w_result = r_a & r_b;
            OP_ORR:         w_result = r_a | r_b;
            OP_EOR:         w_result = r_a ^ r_b;
            OP_MOV:         w_result = r_b;
            OP_MVN:         w_result = ~r_b;
            default:        w_result = '0;
        endcase
        w_writes = !r_op[OP_W-1] && (r_op != OP_CMP);
    end

    // State register; busy is registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rdy_s) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = w_writes ? S_WB_LO : S_DRAIN;
            S_WB_LO: if (!w_rdyw_s) w_state_next = S_WB_HI;
            S_WB_HI: if (w_rdyw_s) w_state_next = S_DRAIN;
            S_DRAIN: if (!w_rdy_s) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bundle capture, result register and both toggle handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_dst    <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_trig   <= 1'b0;
            r_trigw  <= 1'b0;
            r_wsent  <= 1'b0;
            r_addrw  <= '0;
            r_dataw  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rdy_s) begin
                        r_a   <= data1In;
                        r_b   <= data2In;
                        r_dst <= data3In[IDX_W-1:0];
                        r_op  <= typeIn;
                    end
                end
                S_EXEC: begin
                    r_result <= w_result;
                    r_trig   <= ~r_trig;
                    r_wsent  <= 1'b0;
                end
                S_WB_LO: begin
                    if (!r_wsent) begin
                        r_addrw <= DATA_WIDTH'(r_dst);
                        r_dataw <= r_result;
                        r_trigw <= ~r_trigw;
                        r_wsent <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EXEC_FLAGS_EN
    logic       r_s;
    logic [3:0] r_flags;
    logic [3:0] w_flags;
    logic       w_flag_upd;
    logic       w_unused;

    assign w_unused = &{1'b0, data3In[MSB:IDX_W], data4In[MSB:1]};
    assign flagsOut = r_flags;

    // Capture the S bit alongside the bundle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s <= 1'b0;
        end else if (r_state == S_IDLE && w_rdy_s) begin
            r_s <= data4In[0];
        end
    end

    // NZCV next value; logical ops keep C and V
    always_comb begin
        w_flags    = r_flags;
        w_flag_upd = (r_s && !r_op[OP_W-1]) || (r_op == OP_CMP);
        w_flags[3] = w_result[MSB];
        w_flags[2] = (w_result == '0);
        case (r_op)
            OP_ADD: begin
                w_flags[1] = w_sum[DATA_WIDTH];
                w_flags[0] = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_flags[1] = ~w_diff[DATA_WIDTH];
                w_flags[0] = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            default: ;
        endcase
    end

    // Flags register, updated when EXEC retires a flag-setting op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (r_state == S_EXEC && w_flag_upd) begin
            r_flags <= w_flags;
        end
    end
`else
    logic w_unused;

    assign w_unused = &{1'b0, data3In[MSB:IDX_W], data4In, w_sum[DATA_WIDTH], w_diff[DATA_WIDTH]};
    assign flagsOut = 4'b0;
`endif

endmodule
